instruction_loader: RTL and testbench

Program loader that fills instruction memory: the write side of the read-only instruction store the CPU fetches from. It accepts a framed byte stream over a valid/ready handshake from a host link, assembles big-endian instruction words, and issues single-cycle writes to the memory's write port at auto-incrementing addresses. It holds the CPU while loading and reports completion or a framing/checksum error.

---
 rtl/instruction_loader_pkg.sv | 19 +
 rtl/instruction_loader_if.sv | 25 ++
 rtl/xor_checksum.sv | 23 ++
 rtl/instruction_loader.sv | 135 +++++++++++++
 tb/tb_instruction_loader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - loader states and widths shared with instruction_memory and the CPU
package instruction_loader_pkg;

   localparam int BYTE_W                   = 8;
   localparam int DEFAULT_ADDR_SIZE        = 10;
   localparam int DEFAULT_INSTRUCTION_SIZE = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEN_HI  = 3'd1,
      LEN_LO  = 3'd2,
      DATA_HI = 3'd3,
      DATA_LO = 3'd4,
      CHECK   = 3'd5,
      DONE    = 3'd6,
      ERROR   = 3'd7
   } state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - host byte stream in, instruction memory write port out
interface instruction_loader_if
   import instruction_loader_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_SIZE,
   parameter int DATA_W = DEFAULT_INSTRUCTION_SIZE
);
   logic [BYTE_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   // master: host link and memory side; slave: the loader itself
   modport master (
      output in_data, in_valid,
      input  in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/xor_checksum.sv
// rtl/xor_checksum.sv - running XOR over accepted bytes with synchronous clear
module xor_checksum
   import instruction_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              en,
   input  logic [BYTE_W-1:0] data,
   output logic [BYTE_W-1:0] sum
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum ^ data;
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - framed byte stream to instruction memory writes, holds the CPU while loading
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int INSTRUCTION_SIZE      = DEFAULT_INSTRUCTION_SIZE,
   parameter int INSTRUCTION_ADDR_SIZE = DEFAULT_ADDR_SIZE
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   instruction_loader_if.slave  bus,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 err
);

   localparam logic [16:0] CAPACITY = 17'(1) << INSTRUCTION_ADDR_SIZE;

   state_t state_q, state_d;

   logic                             in_ready;
   logic                             accept;
   logic                             start_ok;
   logic [BYTE_W-1:0]                len_hi_q;
   logic [15:0]                      len_q;
   logic [15:0]                      len_full;
   logic [16:0]                      word_cnt_q;
   logic                             last_word;
   logic [BYTE_W-1:0]                hi_q;
   logic                             wr_en_q;
   logic [INSTRUCTION_ADDR_SIZE-1:0] wr_addr_q;
   logic [INSTRUCTION_SIZE-1:0]      wr_data_q;
   logic [BYTE_W-1:0]                sum;
   logic                             sum_en;

   assign accept    = bus.in_valid & in_ready;
   assign start_ok  = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERROR));
   assign len_full  = {len_hi_q, bus.in_data};
   // 17-bit compare so a count equal to the full 16-bit range cannot wrap
   assign last_word = (word_cnt_q + 17'd1) == {1'b0, len_q};
   assign sum_en    = accept & ((state_q == DATA_HI) | (state_q == DATA_LO));

   xor_checksum u_xor_checksum (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start_ok),
      .en    (sum_en),
      .data  (bus.in_data),
      .sum   (sum)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: if (start) state_d = LEN_HI;
         LEN_HI:  if (accept) state_d = LEN_LO;
         LEN_LO: begin
            if (accept) begin
               if ({1'b0, len_full} > CAPACITY) state_d = ERROR;
               else if (len_full == 16'd0)      state_d = CHECK;
               else                             state_d = DATA_HI;
            end
         end
         DATA_HI: if (accept) state_d = DATA_LO;
         DATA_LO: if (accept) state_d = last_word ? CHECK : DATA_HI;
         CHECK:   if (accept) state_d = (bus.in_data == sum) ? DONE : ERROR;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      cpu_hold = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state_q)
         LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: begin
            in_ready = 1'b1;
            cpu_hold = 1'b1;
         end
         DONE:    done = 1'b1;
         ERROR:   err  = 1'b1;
         default: ;
      endcase
   end

   // Write port registers: one-cycle strobe after each completed word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_hi_q   <= '0;
         len_q      <= '0;
         word_cnt_q <= '0;
         hi_q       <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (start_ok) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            wr_addr_q  <= '0;
         end
         if (accept) begin
            case (state_q)
               LEN_HI:  len_hi_q <= bus.in_data;
               LEN_LO:  len_q    <= len_full;
               DATA_HI: hi_q     <= bus.in_data;
               DATA_LO: begin
                  wr_en_q    <= 1'b1;
                  wr_addr_q  <= word_cnt_q[INSTRUCTION_ADDR_SIZE-1:0];
                  wr_data_q  <= INSTRUCTION_SIZE'({hi_q, bus.in_data});
                  word_cnt_q <= word_cnt_q + 17'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed frames against hand-computed writes and status
module tb_instruction_loader;
   import instruction_loader_pkg::*;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic start    = 1'b0;
   logic cpu_hold;
   logic done;
   logic err;

   instruction_loader_if #(.ADDR_W(10), .DATA_W(16)) bus ();

   instruction_loader #(.INSTRUCTION_SIZE(16), .INSTRUCTION_ADDR_SIZE(10)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [9:0]  wa [0:2047];
   logic [15:0] wd [0:2047];
   int          wr_count   = 0;
   int          wr_run     = 0;
   int          wr_run_max = 0;
   logic [7:0]  fr [$];

   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         if (wr_count < 2048) begin
            wa[wr_count] = bus.wr_addr;
            wd[wr_count] = bus.wr_data;
         end
         wr_count++;
         wr_run++;
         if (wr_run > wr_run_max) wr_run_max = wr_run;
      end else begin
         wr_run = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (bus.in_ready !== 1'b1) check("accept_timeout", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic send_fr(input bit gaps);
      foreach (fr[i]) send_byte(fr[i], gaps);
      tick();
      tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
      check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
      check({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
      check({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd0);
      check({tag, "_done"},     32'(done),         32'd0);
      check({tag, "_err"},      32'(err),          32'd0);
      check({tag, "_state"},    32'(dut.state_q),  32'(IDLE));
   endtask

   initial begin
      int base;
      logic [7:0] x;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst_n = 1'b1;
      tick();

      // good two-word load: checksum 81^01^82^01 = 03
      base = wr_count;
      pulse_start();
      check("good_hold_after_start", 32'(cpu_hold), 32'd1);
      fr = '{8'h00, 8'h02, 8'h81, 8'h01, 8'h82, 8'h01, 8'h03};
      send_fr(1'b0);
      check("good_nwr",   32'(wr_count - base), 32'd2);
      check("good_a0",    32'(wa[base]),        32'd0);
      check("good_d0",    32'(wd[base]),        32'h8101);
      check("good_a1",    32'(wa[base+1]),      32'd1);
      check("good_d1",    32'(wd[base+1]),      32'h8201);
      check("good_done",  32'(done),            32'd1);
      check("good_err",   32'(err),             32'd0);
      check("good_hold",  32'(cpu_hold),        32'd0);
      check("good_ready", 32'(bus.in_ready),    32'd0);

      // bad checksum still writes both words
      base = wr_count;
      pulse_start();
      check("restart_done_clr", 32'(done), 32'd0);
      fr = '{8'h00, 8'h02, 8'h81, 8'h01, 8'h82, 8'h01, 8'h04};
      send_fr(1'b0);
      check("badck_nwr",  32'(wr_count - base), 32'd2);
      check("badck_d1",   32'(wd[base+1]),      32'h8201);
      check("badck_err",  32'(err),             32'd1);
      check("badck_done", 32'(done),            32'd0);
      check("badck_hold", 32'(cpu_hold),        32'd0);

      // oversize length 1025
      base = wr_count;
      pulse_start();
      send_byte(8'h04, 1'b0);
      send_byte(8'h01, 1'b0);
      check("over_err_now", 32'(err), 32'd1);
      tick();
      tick();
      check("over_nwr",   32'(wr_count - base), 32'd0);
      check("over_ready", 32'(bus.in_ready),    32'd0);
      check("over_hold",  32'(cpu_hold),        32'd0);

      // empty program
      base = wr_count;
      pulse_start();
      fr = '{8'h00, 8'h00, 8'h00};
      send_fr(1'b0);
      check("empty_done", 32'(done),            32'd1);
      check("empty_err",  32'(err),             32'd0);
      check("empty_nwr",  32'(wr_count - base), 32'd0);

      // gaps plus a start pulse mid-frame that must be ignored
      base = wr_count;
      pulse_start();
      fr = '{8'h00, 8'h02, 8'h81, 8'h01};
      send_fr(1'b1);
      pulse_start();
      check("gap_hold_mid", 32'(cpu_hold), 32'd1);
      fr = '{8'h82, 8'h01, 8'h03};
      send_fr(1'b1);
      check("gap_nwr",  32'(wr_count - base), 32'd2);
      check("gap_a0",   32'(wa[base]),        32'd0);
      check("gap_d0",   32'(wd[base]),        32'h8101);
      check("gap_a1",   32'(wa[base+1]),      32'd1);
      check("gap_d1",   32'(wd[base+1]),      32'h8201);
      check("gap_done", 32'(done),            32'd1);

      // second start after DONE begins again at address 0
      base = wr_count;
      pulse_start();
      fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
      send_fr(1'b0);
      check("again_nwr",  32'(wr_count - base), 32'd1);
      check("again_a0",   32'(wa[base]),        32'd0);
      check("again_d0",   32'(wd[base]),        32'h1234);
      check("again_done", 32'(done),            32'd1);

      // reset after the first data word
      pulse_start();
      fr = '{8'h00, 8'h02, 8'h81, 8'h01};
      send_fr(1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_idle_outputs("midrst");
      base = wr_count;
      pulse_start();
      fr = '{8'h00, 8'h02, 8'h81, 8'h01, 8'h82, 8'h01, 8'h03};
      send_fr(1'b0);
      check("midrst_nwr",  32'(wr_count - base), 32'd2);
      check("midrst_a0",   32'(wa[base]),        32'd0);
      check("midrst_a1",   32'(wa[base+1]),      32'd1);
      check("midrst_d1",   32'(wd[base+1]),      32'h8201);
      check("midrst_done", 32'(done),            32'd1);

      // full capacity: 1024 words of value i, last write to 1023 without wrap
      base = wr_count;
      fr = '{8'h04, 8'h00};
      x = 8'h00;
      for (int i = 0; i < 1024; i++) begin
         fr.push_back(8'(i >> 8));
         fr.push_back(8'(i));
         x = x ^ 8'(i >> 8) ^ 8'(i);
      end
      fr.push_back(x);
      pulse_start();
      send_fr(1'b0);
      check("cap_nwr",   32'(wr_count - base), 32'd1024);
      check("cap_a0",    32'(wa[base]),        32'd0);
      check("cap_alast", 32'(wa[base+1023]),   32'd1023);
      check("cap_dlast", 32'(wd[base+1023]),   32'd1023);
      check("cap_done",  32'(done),            32'd1);
      check("cap_err",   32'(err),             32'd0);

      check("wr_en_one_cycle", 32'(wr_run_max), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

endmodule
